// File: rtl/jt89_mix_multi.sv
// jt89_mix_multi: sequential multi-channel sound mixer.
// A mix request latches all channel samples, gains and mutes. The channels are
// then accumulated one per clock. The total saturates to the output width and
// drives sound, with a one-cycle sample pulse marking each update.
// Optional feature: define JT89_MIX_FILTER_EN to place a STAGES-deep low-pass
// cascade between the saturated mix and sound.

module jt89_mix_multi #(
  parameter int CHN    = 4,
  parameter int W      = 9,
  parameter int OW     = 11,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [CHN*W-1:0]     ch,
  input  logic [CHN*4-1:0]     gain,
  input  logic [CHN-1:0]       mute,
  output logic [OW-1:0]        sound,
  output logic                 sample
);

  localparam int AW   = W + 4 + $clog2(CHN);
  localparam int CW   = (CHN > 1) ? $clog2(CHN) : 1;
  localparam int MAXI = (1 << OW) - 1;

  typedef enum logic [1:0] {IDLE, SUM, OUT} state_t;

  state_t state_q, state_d;

  logic [CHN*W-1:0] ch_q;
  logic [CHN*4-1:0] gain_q;
  logic [CHN-1:0]   mute_q;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    acc_q;

  logic [W-1:0]     cur_ch;
  logic [3:0]       cur_gain;
  logic             cur_mute;
  logic [W+3:0]     prod;
  logic [AW-1:0]    term;
  logic             last_ch;
  logic [OW-1:0]    mix;

  // Select the channel addressed by the scan counter and form its scaled term
  always_comb begin
    cur_ch   = ch_q[cnt_q*W +: W];
    cur_gain = gain_q[cnt_q*4 +: 4];
    cur_mute = mute_q[cnt_q];
    prod     = (W+4)'(cur_ch) * (W+4)'(cur_gain);
    term     = cur_mute ? '0 : AW'(prod >> 3);
    last_ch  = (cnt_q == CW'(CHN-1));
  end

  // Clamp the accumulated total to the largest value the output can hold
  always_comb begin
    if ({1'b0, acc_q} > (AW+1)'(MAXI)) begin
      mix = '1;
    end else begin
      mix = acc_q[OW-1:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: requests are only honoured while idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clk_en) state_d = SUM;
      SUM:     if (last_ch) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Input latch, channel counter and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q   <= '0;
      gain_q <= '0;
      mute_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clk_en) begin
            ch_q   <= ch;
            gain_q <= gain;
            mute_q <= mute;
            cnt_q  <= '0;
            acc_q  <= '0;
          end
        end
        SUM: begin
          acc_q <= acc_q + term;
          if (!last_ch) cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Update strobe, raised for the cycle after OUT
  always_ff @(posedge clk) begin
    if (rst) begin
      sample <= 1'b0;
    end else begin
      sample <= (state_q == OUT);
    end
  end

`ifdef JT89_MIX_FILTER_EN
  logic [OW-1:0] stage_q  [STAGES];
  logic [OW-1:0] stage_in [STAGES];

  // One low-pass step; rounding up when rising lets a constant input be reached exactly
  function automatic logic [OW-1:0] lp_step(input logic [OW-1:0] y, input logic [OW-1:0] x);
    logic [OW:0] s;
    s = {1'b0, y} + {1'b0, x} + {{OW{1'b0}}, (x > y)};
    return s[OW:1];
  endfunction

  // Chain each stage to the previous one, the first stage fed by the mix
  always_comb begin
    stage_in[0] = mix;
    for (int i = 1; i < STAGES; i++) begin
      stage_in[i] = stage_q[i-1];
    end
  end

  // All stages advance together once per completed mix
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (state_q == OUT) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= lp_step(stage_q[i], stage_in[i]);
    end
  end

  assign sound = stage_q[STAGES-1];
`else
  logic [OW-1:0] sound_q;

  // Unfiltered output takes the saturated mix directly
  always_ff @(posedge clk) begin
    if (rst) begin
      sound_q <= '0;
    end else if (state_q == OUT) begin
      sound_q <= mix;
    end
  end

  assign sound = sound_q;
`endif

endmodule

// File: doc/jt89_mix_multi.md
JT89_MIX_MULTI -- requirements
Module: jt89_mix_multi

Interface
REQ-001 SHALL have parameter CHN, default 4: number of input channels, 1..16.
REQ-002 SHALL have parameter W, default 9: unsigned width of each channel sample.
REQ-003 SHALL have parameter OW, default 11: unsigned output width; legal range W..W+4+clog2(CHN).
REQ-004 SHALL have parameter STAGES, default 3: low-pass stage count, 1..4.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port clk_en, input, 1: mix request strobe.
REQ-008 SHALL have port ch, input, CHN*W: channel samples; channel k at bits [k*W +: W].
REQ-009 SHALL have port gain, input, CHN*4: unsigned per-channel gain; channel k at [k*4 +: 4]; 8 = unity.
REQ-010 SHALL have port mute, input, CHN: bit k high forces channel k contribution to 0.
REQ-011 SHALL have port sound, output, OW: mixed, saturated, optionally filtered output.
REQ-012 SHALL have port sample, output, 1: one-cycle pulse marking a sound update.

Function
REQ-013 SHALL implement FSM states IDLE, SUM, OUT.
REQ-014 IDLE: clk_en high SHALL latch ch, gain, mute, clear accumulator and channel counter, go to SUM.
REQ-015 SUM SHALL add one channel per clk cycle, in index order 0..CHN-1, regardless of clk_en.
REQ-016 Channel term SHALL be (ch_k * gain_k) >> 3, truncated, or 0 if mute_k; accumulator width W+4+clog2(CHN), no overflow possible.
REQ-017 After channel CHN-1 is added, FSM SHALL go to OUT; OUT lasts one cycle, then returns to IDLE.
REQ-018 In OUT, the sum SHALL saturate to 2^OW-1 if larger, otherwise pass unchanged (value "mix").
REQ-019 sound and sample SHALL update on the edge leaving OUT; with clk_en at cycle t, sample is high in cycle t+CHN+2 only.
REQ-020 clk_en while in SUM or OUT SHALL be ignored; no request is queued.
REQ-021 Inputs changing after the latch cycle SHALL NOT affect the scan in progress.
REQ-022 gain 0 SHALL contribute 0; gain 15 SHALL give 1.875x (truncated).

Reset
REQ-023 rst SHALL force state IDLE, accumulator 0, counter 0, sound 0, sample 0, all filter stages 0.
REQ-024 rst asserted mid-scan SHALL abort the scan; no sample pulse for it; rst has priority over clk_en.

Configuration
REQ-025 Macro JT89_MIX_FILTER_EN defined SHALL compile in a STAGES-deep low-pass cascade updated once per OUT cycle.
REQ-026 Cascade: stage 0 input = mix, stage i input = stage i-1 register; all stages update simultaneously from pre-edge values; sound = last stage.
REQ-027 Each stage SHALL compute y <= (y + x + (x > y ? 1 : 0)) >> 1 in OW+1 bits, so a constant input is reached exactly.
REQ-028 Macro undefined SHALL give sound = mix directly on the OUT edge; no filter registers exist.

Verification
REQ-029 CHN=4, no macro, ch all 100, gain all 8, mute 0, clk_en pulse at t -> sound=400, sample high at t+6 only.
REQ-030 ch all 511, gain all 15, no macro -> each term 958, sum 3832, sound saturates to 2047.
REQ-031 ch={100,200,300,400}, gain 8, mute=4'b0101 -> sound=600; gain={0,4,8,15} unmuted -> 0+100+300+750=1150.
REQ-032 JT89_MIX_FILTER_EN, STAGES=3, steady mix=400 from reset -> sound monotonic non-decreasing, equals 400 exactly and then holds; then mix=0 -> monotonic down to exactly 0.
REQ-033 clk_en re-pulsed at t+2 and t+4 during a scan -> ignored, one sample pulse at t+6; rst at t+3 -> no pulse, sound 0, next clk_en starts a clean scan.
